// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the N x N result matrix of the systolic
// array on a capture pulse and streams it out row-major, one word per beat,
// over a valid/ready interface with row/column tags and a last flag.
//
// state  | meaning
// IDLE   | no frame held; o_valid low, waiting for i_capture
// STREAM | frame held; presenting snap[o_row][o_col] until every beat drains

module systolic_result_drain #(
  parameter int N = 4,
  parameter int W = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_srst_n,
  input  logic                          i_capture,
  input  logic [N-1:0][N-1:0][W-1:0]    i_c,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [W-1:0]                  o_data,
  output logic [IW-1:0]                 o_row,
  output logic [IW-1:0]                 o_col,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state;
  logic [N-1:0][N-1:0][W-1:0]   snap;
  logic [IW-1:0]                nrow;
  logic [IW-1:0]                ncol;
  logic                         col_end;
  logic                         row_end;
  logic                         n_last;
  logic                         accept_cap;

  // Next beat indices and capture acceptance. A capture is taken in IDLE, or
  // on the edge where the final beat actually transfers so frames chain with
  // no bubble; any other capture while streaming is an overrun.
  always_comb begin
    col_end    = (o_col == IW'(N - 1));
    row_end    = (o_row == IW'(N - 1));
    ncol       = col_end ? '0 : o_col + IW'(1);
    nrow       = o_row;
    if (col_end) begin
      nrow = row_end ? '0 : o_row + IW'(1);
    end
    n_last     = (nrow == IW'(N - 1)) && (ncol == IW'(N - 1));
    accept_cap = i_capture && ((state == IDLE) || (i_ready && o_last));
  end

  // FSM, snapshot and all outputs; o_data is loaded only from registers so
  // nothing downstream sees a combinational path from i_c or i_ready.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state     <= IDLE;
      snap      <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      o_row     <= '0;
      o_col     <= '0;
      o_last    <= 1'b0;
      o_data    <= '0;
    end else if (accept_cap) begin
      state   <= STREAM;
      snap    <= i_c;
      o_row   <= '0;
      o_col   <= '0;
      o_data  <= i_c[0][0];
      o_last  <= (N == 1);
      o_valid <= 1'b1;
      o_busy  <= 1'b1;
    end else if (state == STREAM) begin
      if (i_capture) begin
        o_overrun <= 1'b1;
      end
      if (i_ready) begin
        if (o_last) begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_last  <= 1'b0;
          o_row   <= '0;
          o_col   <= '0;
        end else begin
          o_row  <= nrow;
          o_col  <= ncol;
          o_data <= snap[nrow][ncol];
          o_last <= n_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: N=4 main instance plus an N=1
// instance for the single-beat corner.

module tb_systolic_result_drain;

  logic clk;
  logic srst_n;

  // N=4 instance
  logic                      capture;
  logic [3:0][3:0][31:0]     c;
  logic                      valid;
  logic                      ready;
  logic [31:0]               data;
  logic [1:0]                row;
  logic [1:0]                col;
  logic                      last;
  logic                      busy;
  logic                      overrun;

  // N=1 instance
  logic                      capture1;
  logic [0:0][0:0][31:0]     c1;
  logic                      valid1;
  logic                      ready1;
  logic [31:0]               data1;
  logic [0:0]                row1;
  logic [0:0]                col1;
  logic                      last1;
  logic                      busy1;
  logic                      overrun1;

  int checks = 0;
  int errors = 0;

  systolic_result_drain #(.N(4), .W(32)) u_dut (
    .i_clk(clk), .i_srst_n(srst_n), .i_capture(capture), .i_c(c),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_row(row),
    .o_col(col), .o_last(last), .o_busy(busy), .o_overrun(overrun)
  );

  systolic_result_drain #(.N(1), .W(32)) u_dut1 (
    .i_clk(clk), .i_srst_n(srst_n), .i_capture(capture1), .i_c(c1),
    .o_valid(valid1), .i_ready(ready1), .o_data(data1), .o_row(row1),
    .o_col(col1), .o_last(last1), .o_busy(busy1), .o_overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: basic frame, 1: overrun intruder, 2: back-to-back second frame
  function automatic logic [31:0] exp_word(input int mode, input int i, input int j);
    case (mode)
      0:       return 32'(32'h100 * i + j);
      1:       return 32'(32'hBEEF0000 + 16 * i + j);
      default: return 32'(32'hA000 + 4 * i + j);
    endcase
  endfunction

  task automatic set_c(input int mode);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        c[i][j] = exp_word(mode, i, j);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    srst_n = 1'b0;
    tick;
    srst_n = 1'b1;
  endtask

  task automatic test_reset;
    srst_n = 1'b0;
    tick;
    tick;
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    checks++; if (row !== 2'd0 || col !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d,%0d want 0,0", row, col); end
    checks++; if (last !== 1'b0)    begin errors++; $display("FAIL reset_last got %0b want 0", last); end
    checks++; if (data !== 32'h0)   begin errors++; $display("FAIL reset_data got %h want 0", data); end
    checks++; if (valid1 !== 1'b0 || data1 !== 32'h0) begin errors++; $display("FAIL reset_n1 got v=%0b d=%h want 0", valid1, data1); end
    srst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    set_c(0);
    ready = 1'b1;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d got %0b want 1", k, valid); end
      checks++; if (data !== exp_word(0, k / 4, k % 4)) begin errors++; $display("FAIL basic_data beat %0d got %h want %h", k, data, exp_word(0, k / 4, k % 4)); end
      checks++; if (row !== 2'(k / 4) || col !== 2'(k % 4)) begin errors++; $display("FAIL basic_idx beat %0d got %0d,%0d want %0d,%0d", k, row, col, k / 4, k % 4); end
      checks++; if (last !== (k == 15)) begin errors++; $display("FAIL basic_last beat %0d got %0b want %0b", k, last, (k == 15)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy beat %0d got %0b want 1", k, busy); end
      tick;
    end
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end got v=%0b b=%0b want 0,0", valid, busy); end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int cyc = 0;
    set_c(0);
    ready = 1'b0;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    while (k < 16 && cyc < 200) begin
      ready = ((cyc % 3) == 0);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %0b want 1", cyc, valid); end
      checks++; if (data !== exp_word(0, k / 4, k % 4)) begin errors++; $display("FAIL bp_data beat %0d got %h want %h", k, data, exp_word(0, k / 4, k % 4)); end
      checks++; if (row !== 2'(k / 4) || col !== 2'(k % 4) || last !== (k == 15)) begin errors++; $display("FAIL bp_tags beat %0d got %0d,%0d,%0b want %0d,%0d,%0b", k, row, col, last, k / 4, k % 4, (k == 15)); end
      if (ready) k++;
      tick;
      cyc++;
    end
    checks++; if (k != 16) begin errors++; $display("FAIL bp_timeout got %0d beats want 16", k); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b want 0", valid); end
    ready = 1'b1;
  endtask

  task automatic test_overrun;
    set_c(0);
    ready = 1'b1;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        set_c(1);
        capture = 1'b1;
      end
      checks++; if (data !== exp_word(0, k / 4, k % 4) || last !== (k == 15)) begin errors++; $display("FAIL ovr_data beat %0d got %h/%0b want %h/%0b", k, data, last, exp_word(0, k / 4, k % 4), (k == 15)); end
      checks++; if (overrun !== (k > 5)) begin errors++; $display("FAIL ovr_flag beat %0d got %0b want %0b", k, overrun, (k > 5)); end
      tick;
      capture = 1'b0;
    end
    checks++; if (valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_end got v=%0b o=%0b want 0,1", valid, overrun); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clear got %0b want 0", overrun); end
    set_c(0);
    ready = 1'b1;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    for (int k = 0; k < 32; k++) begin
      int m = (k < 16) ? 0 : 2;
      int b = k % 16;
      if (k == 15) begin
        set_c(2);
        capture = 1'b1;
      end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %0b want 1", k, valid); end
      checks++; if (data !== exp_word(m, b / 4, b % 4)) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", k, data, exp_word(m, b / 4, b % 4)); end
      checks++; if (row !== 2'(b / 4) || col !== 2'(b % 4) || last !== (b == 15)) begin errors++; $display("FAIL b2b_tags beat %0d got %0d,%0d,%0b want %0d,%0d,%0b", k, row, col, last, b / 4, b % 4, (b == 15)); end
      tick;
      capture = 1'b0;
    end
    checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%0b o=%0b want 0,0", valid, overrun); end
  endtask

  task automatic test_reset_mid_frame;
    set_c(0);
    ready = 1'b1;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    for (int k = 0; k < 6; k++) begin
      capture = (k == 2);
      tick;
    end
    capture = 1'b0;
    checks++; if (data !== exp_word(0, 1, 2) || overrun !== 1'b1) begin errors++; $display("FAIL rmid_pre got %h/%0b want %h/1", data, overrun, exp_word(0, 1, 2)); end
    do_reset;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state got v=%0b b=%0b want 0,0", valid, busy); end
    checks++; if (overrun !== 1'b0 || data !== 32'h0) begin errors++; $display("FAIL rmid_clear got o=%0b d=%h want 0,0", overrun, data); end
    tick;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_nobeat got %0b want 0", valid); end
    set_c(2);
    capture = 1'b1;
    tick;
    capture = 1'b0;
    checks++; if (valid !== 1'b1 || row !== 2'd0 || col !== 2'd0 || data !== 32'hA000) begin errors++; $display("FAIL rmid_restart got v=%0b %0d,%0d %h want 1 0,0 a000", valid, row, col, data); end
    for (int k = 0; k < 16; k++) tick;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_drain got %0b want 0", valid); end
  endtask

  task automatic test_n1;
    c1[0][0] = 32'hDEADBEEF;
    ready1 = 1'b0;
    capture1 = 1'b1;
    tick;
    capture1 = 1'b0;
    c1[0][0] = 32'h0;
    checks++; if (valid1 !== 1'b1 || data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL n1_beat got v=%0b d=%h want 1 deadbeef", valid1, data1); end
    checks++; if (last1 !== 1'b1 || row1 !== 1'b0 || col1 !== 1'b0) begin errors++; $display("FAIL n1_tags got l=%0b %0d,%0d want 1 0,0", last1, row1, col1); end
    tick;
    checks++; if (valid1 !== 1'b1 || data1 !== 32'hDEADBEEF || last1 !== 1'b1) begin errors++; $display("FAIL n1_stall got v=%0b d=%h l=%0b want 1 deadbeef 1", valid1, data1, last1); end
    ready1 = 1'b1;
    tick;
    checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0 || overrun1 !== 1'b0) begin errors++; $display("FAIL n1_end got v=%0b b=%0b o=%0b want 0,0,0", valid1, busy1, overrun1); end
  endtask

  initial begin
    srst_n   = 1'b0;
    capture  = 1'b0;
    ready    = 1'b0;
    c        = '0;
    capture1 = 1'b0;
    ready1   = 1'b0;
    c1       = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_overrun;
    test_back_to_back;
    test_reset_mid_frame;
    test_n1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
